wilton_sb_dir: RTL and testbench

//  Parametrised Wilton switch box with unidirectional tracks. Each side has WIDTH tracks in and WIDTH tracks out.

---
 rtl/wilton_sb_dir_pkg.sv | 26 ++
 rtl/wilton_sb_dir_cfg_chain.sv | 91 +++++++++
 rtl/wilton_sb_dir.sv | 96 +++++++++
 tb/tb_wilton_sb_dir.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wilton_sb_dir_pkg.sv
// Shared types and index helpers for the unidirectional Wilton switch box.
// Side and turn encodings match the 2-bit per-track select field in the cfg word.
package wilton_pkg;

  typedef enum logic [1:0] {N = 2'd0, E = 2'd1, S = 2'd2, W = 2'd3} dir_e;
  typedef enum logic [1:0] {OFF = 2'd0, LEFT = 2'd1, STRAIGHT = 2'd2, RIGHT = 2'd3} turn_e;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, LOADED = 2'd2} cfg_state_e;

  localparam int NUM_SIDES = 4;
  localparam int SEL_W     = 2;

  // The turn code doubles as the side offset: left=+1, straight=+2, right=+3.
  function automatic int src_side(input int d, input turn_e turn);
    return (d + int'(turn)) % NUM_SIDES;
  endfunction

  function automatic int src_track(input int t, input turn_e turn, input int width,
                                   input int shift);
    case (turn)
      LEFT:    return (t + shift) % width;
      RIGHT:   return (t + width - shift) % width;
      default: return t;
    endcase
  endfunction

endpackage

// File: rtl/wilton_sb_dir_cfg_chain.sv
// Serial shadow register with fill counter, even-parity check and an active
// register that only changes on a successful commit.
module wilton_cfg_chain
  import wilton_pkg::*;
#(
  parameter  int L     = 33,
  localparam int CW    = L - 1,
  localparam int CNT_W = $clog2(L + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_in,
  input  logic          cfg_commit,
  output logic          cfg_out,
  output logic          cfg_full,
  output logic          cfg_err,
  output logic          cfg_valid,
  output logic [CW-1:0] active_word
);

  localparam logic [CNT_W-1:0] CNT_L = CNT_W'(L);

  logic [L-1:0]     sr;
  logic [CNT_W-1:0] cnt, cnt_nx;
  cfg_state_e       state, state_nx;
  logic             err_nx, valid_nx;
  logic             do_shift, do_load;
  logic             parity_ok;

  assign parity_ok = ~(^sr);
  assign cfg_out   = sr[L-1];
  assign cfg_full  = (state == LOADED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      cnt         <= '0;
      sr          <= '0;
      active_word <= '0;
      cfg_err     <= 1'b0;
      cfg_valid   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cfg_err   <= err_nx;
      cfg_valid <= valid_nx;
      if (do_shift) sr <= {sr[L-2:0], cfg_in};
      if (do_load)  active_word <= sr[L-1:1];
    end
  end

  // Commit takes priority over shifting so the checked frame is the one loaded.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = cfg_err;
    valid_nx = cfg_valid;
    do_shift = 1'b0;
    do_load  = 1'b0;
    if (cfg_commit) begin
      if (state == LOADED) begin
        state_nx = EMPTY;
        cnt_nx   = '0;
        if (parity_ok) begin
          do_load  = 1'b1;
          valid_nx = 1'b1;
          err_nx   = 1'b0;
        end else begin
          err_nx = 1'b1;
        end
      end else begin
        err_nx = 1'b1;
      end
    end else if (cfg_en) begin
      do_shift = 1'b1;
      case (state)
        EMPTY: begin
          cnt_nx   = CNT_W'(1);
          state_nx = FILLING;
        end
        FILLING: begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt_nx == CNT_L) state_nx = LOADED;
        end
        default: cnt_nx = CNT_L;
      endcase
    end
  end

endmodule

// File: rtl/wilton_sb_dir.sv
// Wilton switch box, unidirectional tracks: every output track is a 4:1 mux
// (off/left/straight/right) over the other three sides, optionally registered.
module wilton_sb_dir
  import wilton_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int WILTON_SHIFT = 1,
  parameter int REG_OUT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_in,
  output logic             cfg_out,
  input  logic             cfg_commit,
  output logic             cfg_full,
  output logic             cfg_err,
  output logic             cfg_valid,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] e_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] w_in,
  output logic [WIDTH-1:0] n_out,
  output logic [WIDTH-1:0] e_out,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] w_out
);

  localparam int CW = NUM_SIDES * WIDTH * SEL_W;
  localparam int NT = NUM_SIDES * WIDTH;

  logic [CW-1:0] active_word;
  logic [NT-1:0] in_flat;
  logic [NT-1:0] out_p0;
  logic [NT-1:0] out_p1;

  wilton_cfg_chain #(.L(CW + 1)) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_commit (cfg_commit),
    .cfg_out    (cfg_out),
    .cfg_full   (cfg_full),
    .cfg_err    (cfg_err),
    .cfg_valid  (cfg_valid),
    .active_word(active_word)
  );

  assign in_flat[int'(N)*WIDTH +: WIDTH] = n_in;
  assign in_flat[int'(E)*WIDTH +: WIDTH] = e_in;
  assign in_flat[int'(S)*WIDTH +: WIDTH] = s_in;
  assign in_flat[int'(W)*WIDTH +: WIDTH] = w_in;

  // Stage p0: per-track source selection
  for (genvar d = 0; d < NUM_SIDES; d++) begin : g_side
    for (genvar t = 0; t < WIDTH; t++) begin : g_track
      localparam int IDX_L = src_side(d, LEFT) * WIDTH + src_track(t, LEFT, WIDTH, WILTON_SHIFT);
      localparam int IDX_S = src_side(d, STRAIGHT) * WIDTH + src_track(t, STRAIGHT, WIDTH, WILTON_SHIFT);
      localparam int IDX_R = src_side(d, RIGHT) * WIDTH + src_track(t, RIGHT, WIDTH, WILTON_SHIFT);

      turn_e sel;
      logic  bit_o;

      assign sel = turn_e'(active_word[(d*WIDTH + t)*SEL_W +: SEL_W]);

      always_comb begin
        bit_o = 1'b0;
        case (sel)
          LEFT:     bit_o = in_flat[IDX_L];
          STRAIGHT: bit_o = in_flat[IDX_S];
          RIGHT:    bit_o = in_flat[IDX_R];
          default:  bit_o = 1'b0;
        endcase
      end

      assign out_p0[d*WIDTH + t] = bit_o;
    end
  end

  // Stage p1: optional output flops, cleared with the config so the fabric stays quiet
  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) out_p1 <= '0;
      else     out_p1 <= out_p0;
    end
  end else begin : g_comb
    assign out_p1 = out_p0;
  end

  assign n_out = out_p1[int'(N)*WIDTH +: WIDTH];
  assign e_out = out_p1[int'(E)*WIDTH +: WIDTH];
  assign s_out = out_p1[int'(S)*WIDTH +: WIDTH];
  assign w_out = out_p1[int'(W)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_wilton_sb_dir.sv
// Bench for wilton_sb_dir: two chained instances (WIDTH=4, REG_OUT=1) with a
// routing scoreboard fed by a reference mux model.
module tb_wilton_sb_dir;

  localparam int WD = 4;
  localparam int SH = 1;
  localparam int CW = 8 * WD;
  localparam int L  = CW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic cfg_en0, cfg_en1, cfg_in0, cfg_commit0, cfg_commit1;
  logic cfg_out0, cfg_out1, full0, full1, err0, err1, valid0, valid1;
  logic [WD-1:0] n_in, e_in, s_in, w_in;
  logic [WD-1:0] n0, e0, s0, w0, n1, e1, s1, w1;

  wilton_sb_dir #(.WIDTH(WD), .WILTON_SHIFT(SH), .REG_OUT(1)) u0 (
    .clk(clk), .rst(rst), .cfg_en(cfg_en0), .cfg_in(cfg_in0), .cfg_out(cfg_out0),
    .cfg_commit(cfg_commit0), .cfg_full(full0), .cfg_err(err0), .cfg_valid(valid0),
    .n_in(n_in), .e_in(e_in), .s_in(s_in), .w_in(w_in),
    .n_out(n0), .e_out(e0), .s_out(s0), .w_out(w0)
  );

  wilton_sb_dir #(.WIDTH(WD), .WILTON_SHIFT(SH), .REG_OUT(1)) u1 (
    .clk(clk), .rst(rst), .cfg_en(cfg_en1), .cfg_in(cfg_out0), .cfg_out(cfg_out1),
    .cfg_commit(cfg_commit1), .cfg_full(full1), .cfg_err(err1), .cfg_valid(valid1),
    .n_in(n_in), .e_in(e_in), .s_in(s_in), .w_in(w_in),
    .n_out(n1), .e_out(e1), .s_out(s1), .w_out(w1)
  );

  int nerr = 0;
  int nchk = 0;
  logic [CW-1:0]   mw0, mw1;
  logic [8*WD-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [4*WD-1:0] route(input logic [CW-1:0] wd, input logic [4*WD-1:0] inb);
    logic [4*WD-1:0] r;
    logic [1:0] sel;
    r = '0;
    for (int d = 0; d < 4; d++)
      for (int t = 0; t < WD; t++) begin
        sel = wd[(d*WD + t)*2 +: 2];
        case (sel)
          2'b01:   r[d*WD + t] = inb[((d+1)%4)*WD + (t+SH)%WD];
          2'b10:   r[d*WD + t] = inb[((d+2)%4)*WD + t];
          2'b11:   r[d*WD + t] = inb[((d+3)%4)*WD + (t+WD-SH)%WD];
          default: r[d*WD + t] = 1'b0;
        endcase
      end
    return r;
  endfunction

  task automatic drive_vec(input logic [WD-1:0] n, input logic [WD-1:0] e,
                           input logic [WD-1:0] s, input logic [WD-1:0] w);
    logic [4*WD-1:0] inb;
    logic [8*WD-1:0] exp;
    n_in = n; e_in = e; s_in = s; w_in = w;
    inb = {w, s, e, n};
    sb_q.push_back({route(mw1, inb), route(mw0, inb)});
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    chk("route", {w1, s1, e1, n1, w0, s0, e0, n0}, exp);
  endtask

  task automatic rand_vec();
    logic [31:0] r;
    r = $urandom;
    drive_vec(r[3:0], r[7:4], r[11:8], r[15:12]);
  endtask

  task automatic shift_bit(input logic b, input logic en1);
    cfg_in0 = b; cfg_en0 = 1'b1; cfg_en1 = en1;
    @(posedge clk); #1;
    cfg_en0 = 1'b0; cfg_en1 = 1'b0;
  endtask

  task automatic shift_range(input logic [L-1:0] fr, input int hi, input int lo, input logic en1);
    for (int i = hi; i >= lo; i--) shift_bit(fr[i], en1);
  endtask

  function automatic logic [L-1:0] mk_frame(input logic [CW-1:0] wd, input logic flip);
    return {wd, (^wd) ^ flip};
  endfunction

  task automatic commit(input logic c0, input logic c1);
    cfg_commit0 = c0; cfg_commit1 = c1;
    @(posedge clk); #1;
    cfg_commit0 = 1'b0; cfg_commit1 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0]  wd, wd_a, wd_b;
    logic [L-1:0]   fr;
    logic [31:0]    r;
    cfg_en0 = 0; cfg_en1 = 0; cfg_in0 = 0; cfg_commit0 = 0; cfg_commit1 = 0;
    mw0 = '0; mw1 = '0;
    n_in = 4'hF; e_in = 4'hA; s_in = 4'h5; w_in = 4'h3;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {w1, s1, e1, n1, w0, s0, e0, n0}, 0);
    chk("rst_full", full0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cfg_out", cfg_out0, 0);
    rst = 1'b0;
    repeat (3) rand_vec();

    // 2: straight route N0 <- S0
    wd = '0; wd[1:0] = 2'b10;
    shift_range(mk_frame(wd, 1'b0), L-1, 0, 1'b0);
    chk("t2_full", full0, 1);
    commit(1'b1, 1'b0);
    mw0 = wd;
    chk("t2_valid", valid0, 1);
    chk("t2_err", err0, 0);
    chk("t2_full_clr", full0, 0);
    drive_vec(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    chk("t2_n_out", n0, 4'b0001);
    repeat (3) rand_vec();

    // 3: left turn E2 <- S3
    wd = '0; wd[13:12] = 2'b01;
    shift_range(mk_frame(wd, 1'b0), L-1, 0, 1'b0);
    commit(1'b1, 1'b0);
    mw0 = wd;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      drive_vec(r[3:0], r[7:4], {i[0], r[10:8]}, r[15:12]);
      chk("t3_e2", e0[2], i[0]);
    end

    // 5: early commit is rejected but the partial frame is kept
    wd = $urandom;
    fr = mk_frame(wd, 1'b0);
    shift_range(fr, L-1, L-10, 1'b0);
    commit(1'b1, 1'b0);
    chk("t5_early_err", err0, 1);
    chk("t5_early_full", full0, 0);
    shift_range(fr, L-11, 1, 1'b0);
    chk("t5_not_full", full0, 0);
    shift_bit(fr[0], 1'b0);
    chk("t5_full", full0, 1);
    cfg_en0 = 1'b1; cfg_in0 = ~fr[0];
    commit(1'b1, 1'b0);
    cfg_en0 = 1'b0;
    mw0 = wd;
    chk("t5_err_clr", err0, 0);
    chk("t5_shift_suppr", cfg_out0, wd[CW-1]);
    repeat (4) rand_vec();

    // 4: bad parity keeps previous routing
    wd = $urandom;
    shift_range(mk_frame(wd, 1'b1), L-1, 0, 1'b0);
    commit(1'b1, 1'b0);
    chk("t4_err", err0, 1);
    chk("t4_valid", valid0, 1);
    repeat (4) rand_vec();

    // 6: chained programming of both instances
    wd_a = {$urandom}; wd_b = {$urandom};
    shift_range(mk_frame(wd_a, 1'b0), L-1, 0, 1'b1);
    shift_range(mk_frame(wd_b, 1'b0), L-1, 0, 1'b1);
    chk("t6_full0", full0, 1);
    chk("t6_full1", full1, 1);
    commit(1'b1, 1'b1);
    mw0 = wd_b; mw1 = wd_a;
    chk("t6_err0", err0, 0);
    chk("t6_valid1", valid1, 1);
    repeat (6) rand_vec();

    // 6b: reset in the middle of a chained frame
    shift_range(mk_frame(wd_b, 1'b0), L-1, L-20, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_async", {w1, s1, e1, n1, w0, s0, e0, n0}, 0);
    mw0 = '0; mw1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_rst_valid", {valid1, valid0}, 0);
    chk("t6_rst_full", {full1, full0}, 0);
    chk("t6_rst_err", {err1, err0}, 0);
    chk("t6_rst_cfg_out", {cfg_out1, cfg_out0}, 0);
    repeat (4) rand_vec();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
